// File: rtl/ins_queue_mp.sv
// ins_queue_mp: multi-port circular instruction queue between fetch and decode.
// Defining INS_QUEUE_BYPASS_EN adds a zero-latency in->out forward while the queue is empty.
module ins_queue_mp #(
  parameter int XLEN         = 32,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PTR_WIDTH    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [FETCH_WIDTH-1:0]       in_valid,
  input  logic [FETCH_WIDTH*XLEN-1:0]  in_pc,
  input  logic [FETCH_WIDTH*XLEN-1:0]  in_next_pc,
  input  logic [FETCH_WIDTH*XLEN-1:0]  in_instr,
  output logic                         in_ready,
  output logic [DECODE_WIDTH-1:0]      out_valid,
  output logic [DECODE_WIDTH*XLEN-1:0] out_pc,
  output logic [DECODE_WIDTH*XLEN-1:0] out_next_pc,
  output logic [DECODE_WIDTH*XLEN-1:0] out_instr,
  input  logic [DECODE_WIDTH-1:0]      out_ready,
  output logic [PTR_WIDTH:0]           buf_count,
  output logic                         buf_empty,
  output logic                         buf_full
);

  localparam int CW = PTR_WIDTH + 1;

  logic [XLEN-1:0]      mem_pc_r    [DEPTH];
  logic [XLEN-1:0]      mem_npc_r   [DEPTH];
  logic [XLEN-1:0]      mem_instr_r [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 in_ready_r;
  logic                 buf_empty_r;
  logic                 buf_full_r;

  logic                    bypass_s;
  logic [DECODE_WIDTH-1:0] out_valid_s;
  logic                    pop_run_s;
  logic [CW-1:0]           n_pop_s;
  logic [CW-1:0]           n_pop_mem_s;
  logic [CW-1:0]           n_skip_s;
  logic [CW-1:0]           n_wr_s;
  logic [CW-1:0]           count_next_s;
  logic [FETCH_WIDTH-1:0]  wr_en_s;
  logic [PTR_WIDTH-1:0]    wr_idx_s [FETCH_WIDTH];

`ifdef INS_QUEUE_BYPASS_EN
  assign bypass_s = (count_r == {CW{1'b0}}) && !flush;
`else
  assign bypass_s = 1'b0;
`endif

  // Read lanes: j-th oldest stored entry, or the fetch lane itself while bypassing.
  always_comb begin
    out_valid_s = '0;
    out_pc      = '0;
    out_next_pc = '0;
    out_instr   = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
`ifdef INS_QUEUE_BYPASS_EN
      if (bypass_s) begin
        if (j < FETCH_WIDTH) begin
          out_valid_s[j]               = in_valid[j] & in_ready_r;
          out_pc[j*XLEN +: XLEN]       = in_pc[j*XLEN +: XLEN];
          out_next_pc[j*XLEN +: XLEN]  = in_next_pc[j*XLEN +: XLEN];
          out_instr[j*XLEN +: XLEN]    = in_instr[j*XLEN +: XLEN];
        end else begin
          out_valid_s[j] = 1'b0;
        end
      end else if (count_r > CW'(j)) begin
`else
      if (count_r > CW'(j)) begin
`endif
        // Invalid lanes are forced to zero so no uninitialised storage leaks out.
        out_valid_s[j]              = 1'b1;
        out_pc[j*XLEN +: XLEN]      = mem_pc_r[rd_ptr_r + PTR_WIDTH'(j)];
        out_next_pc[j*XLEN +: XLEN] = mem_npc_r[rd_ptr_r + PTR_WIDTH'(j)];
        out_instr[j*XLEN +: XLEN]   = mem_instr_r[rd_ptr_r + PTR_WIDTH'(j)];
      end else begin
        out_valid_s[j] = 1'b0;
      end
    end
  end

  // Pop count: consumption stops at the first lane that is not both valid and ready.
  always_comb begin
    n_pop_s   = '0;
    pop_run_s = 1'b1;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (pop_run_s && out_valid_s[j] && out_ready[j]) begin
        n_pop_s = n_pop_s + CW'(1);
      end else begin
        pop_run_s = 1'b0;
      end
    end
  end

  // Bypassed lanes that decode took this cycle never touch storage.
  assign n_skip_s    = bypass_s ? n_pop_s : {CW{1'b0}};
  assign n_pop_mem_s = bypass_s ? {CW{1'b0}} : n_pop_s;

  // Push lanes: written lanes are packed in lane order starting at wr_ptr.
  always_comb begin
    n_wr_s  = '0;
    wr_en_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx_s[i] = wr_ptr_r + n_wr_s[PTR_WIDTH-1:0];
      if (!flush && in_ready_r && in_valid[i] && (CW'(i) >= n_skip_s)) begin
        wr_en_s[i] = 1'b1;
        n_wr_s     = n_wr_s + CW'(1);
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  assign count_next_s = count_r + n_wr_s - n_pop_mem_s;

  // Pointer, occupancy and status registers; flush outranks push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      buf_empty_r <= 1'b1;
      buf_full_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      buf_empty_r <= 1'b1;
      buf_full_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_r + n_wr_s[PTR_WIDTH-1:0];
      rd_ptr_r    <= rd_ptr_r + n_pop_mem_s[PTR_WIDTH-1:0];
      count_r     <= count_next_s;
      in_ready_r  <= (CW'(DEPTH) - count_next_s) >= CW'(FETCH_WIDTH);
      buf_empty_r <= (count_next_s == {CW{1'b0}});
      buf_full_r  <= (count_next_s == CW'(DEPTH));
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en_s[i]) begin
        mem_pc_r[wr_idx_s[i]]    <= in_pc[i*XLEN +: XLEN];
        mem_npc_r[wr_idx_s[i]]   <= in_next_pc[i*XLEN +: XLEN];
        mem_instr_r[wr_idx_s[i]] <= in_instr[i*XLEN +: XLEN];
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_s;
  assign buf_count = count_r;
  assign buf_empty = buf_empty_r;
  assign buf_full  = buf_full_r;

endmodule

// File: tb/tb_ins_queue_mp.sv
// Self-checking bench for ins_queue_mp: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_ins_queue_mp;

  localparam int XLEN  = 32;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
`ifdef INS_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [FW-1:0]     in_valid;
  logic [FW*XLEN-1:0] in_pc, in_next_pc, in_instr;
  logic              in_ready;
  logic [DW-1:0]     out_valid;
  logic [DW*XLEN-1:0] out_pc, out_next_pc, out_instr;
  logic [DW-1:0]     out_ready;
  logic [PW:0]       buf_count;
  logic              buf_empty, buf_full;

  always #5 clk = ~clk;

  ins_queue_mp #(.XLEN(XLEN), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_next_pc(in_next_pc), .in_instr(in_instr),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_next_pc(out_next_pc), .out_instr(out_instr),
    .out_ready(out_ready),
    .buf_count(buf_count), .buf_empty(buf_empty), .buf_full(buf_full)
  );

  // Fetch must present a thermometer valid pattern starting at lane 0.
  always @(posedge clk) begin
    if (rst_n) assert (((in_valid + 2'b01) & in_valid) == 2'b00) else $error("in_valid not thermometer: %b", in_valid);
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t lane_in(input int i);
    ent_t e;
    e.pc  = in_pc[i*XLEN +: XLEN];
    e.npc = in_next_pc[i*XLEN +: XLEN];
    e.ins = in_instr[i*XLEN +: XLEN];
    return e;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] ins);
    in_pc[i*XLEN +: XLEN]      = pc;
    in_next_pc[i*XLEN +: XLEN] = npc;
    in_instr[i*XLEN +: XLEN]   = ins;
  endtask

  task automatic drive(input logic [1:0] iv, input logic [1:0] ordy, input logic fl, input logic [31:0] base);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    for (int i = 0; i < FW; i++) begin
      set_lane(i, base + 32'(4*i), base + 32'(4*i) + 32'h1000, ~(base + 32'(4*i)));
    end
  endtask

  // Compare every output against the model state and the inputs currently applied.
  task automatic check_model(input string tag);
    int   sz;
    bit   byp, rdy, ev;
    ent_t e;
    sz  = q.size();
    byp = BYP && (sz == 0) && !flush;
    rdy = (DEPTH - sz) >= FW;
    chk({tag, ".count"}, 64'(buf_count), 64'(sz));
    chk({tag, ".empty"}, 64'(buf_empty), 64'(sz == 0));
    chk({tag, ".full"},  64'(buf_full),  64'(sz == DEPTH));
    chk({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    for (int j = 0; j < DW; j++) begin
      ev = byp ? (in_valid[j] && rdy) : (j < sz);
      chk($sformatf("%s.valid%0d", tag, j), 64'(out_valid[j]), 64'(ev));
      if (ev) begin
        e = byp ? lane_in(j) : q[j];
        chk($sformatf("%s.pc%0d", tag, j),    64'(out_pc[j*XLEN +: XLEN]),      64'(e.pc));
        chk($sformatf("%s.npc%0d", tag, j),   64'(out_next_pc[j*XLEN +: XLEN]), 64'(e.npc));
        chk($sformatf("%s.instr%0d", tag, j), 64'(out_instr[j*XLEN +: XLEN]),   64'(e.ins));
      end
    end
  endtask

  // Advance the reference queue by one clock using the applied inputs.
  task automatic model_update();
    int sz, npop;
    bit run, rdy;
    sz   = q.size();
    rdy  = (DEPTH - sz) >= FW;
    npop = 0;
    run  = 1'b1;
    if (flush) begin
      q.delete();
    end else if (BYP && sz == 0) begin
      for (int j = 0; j < DW; j++) begin
        if (run && in_valid[j] && out_ready[j]) npop++; else run = 1'b0;
      end
      for (int i = npop; i < FW; i++) begin
        if (in_valid[i]) q.push_back(lane_in(i));
      end
    end else begin
      for (int j = 0; j < DW; j++) begin
        if (run && j < sz && out_ready[j]) npop++; else run = 1'b0;
      end
      repeat (npop) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (in_valid[i]) q.push_back(lane_in(i));
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic        fl;
    int          cnt;
    logic [1:0]  ov;
    logic        rdy;
    logic        full;
    logic [31:0] pc0;
  } vec_t;

  vec_t tbl[14];
  logic [1:0]  exp_ov;
  logic [63:0] mask;

  initial begin
    // Row r pushes pc = 0x100 + 8r (+4 on lane 1); expectations are state after the edge.
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 2, 2'b11, 1'b1, 1'b0, 32'h100};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 4, 2'b11, 1'b1, 1'b0, 32'h100};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 6, 2'b11, 1'b1, 1'b0, 32'h100};
    tbl[3]  = '{2'b01, 2'b00, 1'b0, 7, 2'b11, 1'b0, 1'b0, 32'h100};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 7, 2'b11, 1'b0, 1'b0, 32'h100};
    tbl[5]  = '{2'b00, 2'b01, 1'b0, 6, 2'b11, 1'b1, 1'b0, 32'h104};
    tbl[6]  = '{2'b11, 2'b00, 1'b0, 8, 2'b11, 1'b0, 1'b1, 32'h104};
    tbl[7]  = '{2'b11, 2'b00, 1'b0, 8, 2'b11, 1'b0, 1'b1, 32'h104};
    tbl[8]  = '{2'b11, 2'b11, 1'b0, 6, 2'b11, 1'b1, 1'b0, 32'h10c};
    tbl[9]  = '{2'b00, 2'b11, 1'b0, 4, 2'b11, 1'b1, 1'b0, 32'h114};
    tbl[10] = '{2'b00, 2'b10, 1'b0, 4, 2'b11, 1'b1, 1'b0, 32'h114};
    tbl[11] = '{2'b00, 2'b01, 1'b0, 3, 2'b11, 1'b1, 1'b0, 32'h118};
    tbl[12] = '{2'b11, 2'b11, 1'b0, 3, 2'b11, 1'b1, 1'b0, 32'h134};
    tbl[13] = '{2'b11, 2'b11, 1'b1, 0, 2'b00, 1'b1, 1'b0, 32'h0};

    rst_n = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset.count", 64'(buf_count), 64'd0);
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.ready", 64'(in_ready),  64'd1);
    chk("reset.empty", 64'(buf_empty), 64'd1);
    chk("reset.full",  64'(buf_full),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, prefix pop, wrap and flush priority from the table.
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].iv, tbl[r].ordy, tbl[r].fl, 32'h100 + 32'(r*8));
      cycle("tbl");
      drive(2'b00, 2'b00, 1'b0, 32'h0);
      #1;
      chk($sformatf("tbl%0d.count", r), 64'(buf_count), 64'(tbl[r].cnt));
      chk($sformatf("tbl%0d.valid", r), 64'(out_valid), 64'(tbl[r].ov));
      chk($sformatf("tbl%0d.ready", r), 64'(in_ready),  64'(tbl[r].rdy));
      chk($sformatf("tbl%0d.full", r),  64'(buf_full),  64'(tbl[r].full));
      chk($sformatf("tbl%0d.empty", r), 64'(buf_empty), 64'(tbl[r].cnt == 0));
      if (tbl[r].ov[0]) chk($sformatf("tbl%0d.pc0", r), 64'(out_pc[31:0]), 64'(tbl[r].pc0));
    end

    // Park both pointers at 7 with an empty queue.
    drive(2'b11, 2'b00, 1'b0, 32'h400); cycle("park");
    drive(2'b11, 2'b00, 1'b0, 32'h408); cycle("park");
    drive(2'b11, 2'b00, 1'b0, 32'h410); cycle("park");
    drive(2'b01, 2'b00, 1'b0, 32'h418); cycle("park");
    drive(2'b00, 2'b11, 1'b0, 32'h0);   cycle("park");
    drive(2'b00, 2'b11, 1'b0, 32'h0);   cycle("park");
    drive(2'b00, 2'b11, 1'b0, 32'h0);   cycle("park");
    drive(2'b00, 2'b01, 1'b0, 32'h0);   cycle("park");
    chk("park.count", 64'(buf_count), 64'd0);

    drive(2'b11, 2'b11, 1'b0, 32'h200); cycle("wrap");
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    #1;
    exp_ov = BYP ? 2'b00 : 2'b11;
    mask   = {{32{exp_ov[1]}}, {32{exp_ov[0]}}};
    chk("wrap.valid", 64'(out_valid), 64'(exp_ov));
    chk("wrap.pc", 64'(out_pc) & mask, 64'h00000204_00000200 & mask);
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 2'b11, 1'b0, 32'h500 + 32'(k*8));
      cycle("conc");
    end
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    #1;
    chk("conc.count", 64'(buf_count), BYP ? 64'd0 : 64'd2);
    chk("conc.pc", 64'(out_pc) & mask, 64'h0000054c_00000548 & mask);

    // Empty-queue bypass behaviour versus one-cycle latency.
    drive(2'b00, 2'b11, 1'b0, 32'h0); cycle("drain");
    drive(2'b11, 2'b01, 1'b0, 32'h300);
    #1;
    chk("byp.same_valid", 64'(out_valid), BYP ? 64'd3 : 64'd0);
    chk("byp.same_pc0", 64'(out_pc[31:0]) & {32'h0, {32{BYP}}}, 64'h300 & {32'h0, {32{BYP}}});
    cycle("byp");
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    #1;
    chk("byp.next_count", 64'(buf_count), BYP ? 64'd1 : 64'd2);
    chk("byp.next_pc0", 64'(out_pc[31:0]), BYP ? 64'h304 : 64'h300);

    // Random legal traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      in_valid  = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b11);
      out_ready = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < FW; i++) set_lane(i, $urandom, $urandom, $urandom);
      cycle("rnd");
    end

    // Asynchronous reset in the middle of traffic with five entries queued.
    drive(2'b00, 2'b00, 1'b1, 32'h0); cycle("pre");
    drive(2'b11, 2'b00, 1'b0, 32'h600); cycle("pre");
    drive(2'b11, 2'b00, 1'b0, 32'h608); cycle("pre");
    drive(2'b01, 2'b00, 1'b0, 32'h610); cycle("pre");
    chk("pre.count", 64'(buf_count), 64'd5);
    drive(2'b11, 2'b01, 1'b0, 32'h700);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.count", 64'(buf_count), 64'd0);
    chk("areset.valid", 64'(out_valid), 64'd0);
    chk("areset.ready", 64'(in_ready),  64'd1);
    chk("areset.empty", 64'(buf_empty), 64'd1);
    chk("areset.full",  64'(buf_full),  64'd0);
    q.delete();
    @(negedge clk);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 1'b0, 32'h800); cycle("post");
    drive(2'b00, 2'b00, 1'b0, 32'h0);   cycle("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
